gravity_row_reader: RTL
=======================

GRAVITY_ROW_READER -- requirements
Module: gravity_row_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning row address width.
REQ-002 SHALL have parameter MDATA_WIDTH, default 640, meaning bits per binarized row (1 bit per pixel, bit n = column n).
REQ-003 SHALL have parameter CHUNK_WIDTH, default 32, meaning row bits scanned per cycle; MDATA_WIDTH SHALL be a multiple of it.
REQ-004 SHALL have ports CCLK in 1, the single clock; RST_N in 1, the reset, asynchronous and active-low.
REQ-005 SHALL have ports iROW_DONE in 1 (one-cycle pulse: a row is written); iROW_ADDR in ADDR_WIDTH (that row); iROW_BANK in 1 (0 = bank A/WEA, 1 = bank B/WEB).
REQ-006 SHALL have port iFRAME_END in 1, a one-cycle pulse marking the end of the frame.
REQ-007 SHALL have ports oRD_EN out 1; oRD_ADDR out ADDR_WIDTH; oRD_BANK out 1; iRD_DATA in MDATA_WIDTH, valid exactly one cycle after oRD_EN.
REQ-008 SHALL have ports oSUM_S out 21 (set-pixel count); oSUM_X out 32 (sum of set columns); oSUM_Y out 32 (sum of set rows); oVALID out 1 (one-cycle result strobe); oBUSY out 1; oOVERRUN out 1 (sticky).

Function
REQ-009 SHALL implement states IDLE, READ, CAPTURE, SCAN, FINAL.
REQ-010 In IDLE, iROW_DONE SHALL be accepted: addr/bank latched, next state READ.
REQ-011 READ SHALL drive oRD_EN=1 with the latched oRD_ADDR/oRD_BANK for exactly one cycle; CAPTURE SHALL register iRD_DATA into a row shift register.
REQ-012 SCAN SHALL take MDATA_WIDTH/CHUNK_WIDTH cycles (20 at default), processing chunk k (bits k*CHUNK_WIDTH upward) at scan cycle k.
REQ-013 Per chunk: sum_s += popcount; sum_x += sum of the set bit indices; sum_y += popcount * row; all unsigned, with no saturation.
REQ-014 Accept at cycle 0 SHALL give READ at 1, CAPTURE at 2, SCAN at 3..22, and IDLE or FINAL at 23.
REQ-015 oBUSY SHALL be 1 in every state except IDLE.
REQ-016 iROW_DONE while oBUSY=1 SHALL drop that row and set oOVERRUN; oOVERRUN SHALL clear only on reset.
REQ-017 iFRAME_END in IDLE SHALL go to FINAL next cycle; iFRAME_END while busy SHALL set frame_pend and go to FINAL after the current row's SCAN.
REQ-018 iFRAME_END and iROW_DONE in the same IDLE cycle SHALL process the row first, then finalize.
REQ-019 FINAL SHALL copy the accumulators to oSUM_*, clear the accumulators and frame_pend, and pulse oVALID; output values SHALL hold until the next oVALID.
REQ-020 Frame-end latency without the divider SHALL be oVALID one cycle after entering FINAL.

Reset
REQ-021 RST_N low SHALL force IDLE, clear the accumulators and frame_pend, and set all outputs to 0 (oRD_*, oSUM_*, oVALID, oBUSY, oOVERRUN).
REQ-022 Reset mid-SCAN or mid-FINAL SHALL abandon the row or frame with no oVALID.

Configuration
REQ-023 Macro CENTROID_DIV_EN defined SHALL add outputs oCX and oCY (ADDR_WIDTH each) = floor(sum_x/sum_s) and floor(sum_y/sum_s), plus oEMPTY (sum_s==0, giving oCX=oCY=0).
REQ-024 With CENTROID_DIV_EN, FINAL SHALL run two 32-iteration sequential divides in parallel, oVALID SHALL come 33 cycles after entering FINAL, and oBUSY SHALL stay 1 throughout.
REQ-025 Without CENTROID_DIV_EN, oCX, oCY and oEMPTY SHALL be absent and REQ-020 timing SHALL apply.

Structure
REQ-026 Shared package gravity_pkg SHALL hold the state encoding, SUM_S_W=21, SUM_XY_W=32, and DIV_CYCLES=33.
REQ-027 The divider SHALL be sub-module seq_divider (restoring, 32-bit, start/done handshake), instantiated twice only under CENTROID_DIV_EN.

Verification
REQ-028 Row 3 with bits 10..13 set, then iFRAME_END -> oSUM_S=4, oSUM_X=46, oSUM_Y=12, one oVALID.
REQ-029 iROW_DONE at cycle 0 -> oRD_EN only at cycle 1, oBUSY cycles 1..22, second row accepted at cycle 23.
REQ-030 Second iROW_DONE at cycle 10 -> row ignored, oOVERRUN=1, sums unchanged.
REQ-031 iFRAME_END at cycle 5 during a row -> oVALID after SCAN ends, includes that row; next frame sums start at 0.
REQ-032 CENTROID_DIV_EN: rows 2 and 4 each with bits 100 and 102 set -> sum_s=4, oCX=101, oCY=3, oVALID 33 cycles after FINAL; empty frame -> oEMPTY=1, oCX=oCY=0.
REQ-033 RST_N low at scan cycle 8 -> all outputs 0 immediately; post-reset frame end -> oSUM_*=0.

Source files
------------

// File: rtl/gravity_pkg.sv
// gravity_pkg: state encoding and accumulator widths shared by gravity_row_reader and seq_divider.
// Rev 1.0
`default_nettype none

package gravity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SCAN    = 3'd3,
    ST_FINAL   = 3'd4
  } state_t;

  localparam int SUM_S_W    = 21;
  localparam int SUM_XY_W   = 32;
  localparam int DIV_CYCLES = 33;

endpackage

`default_nettype wire

// File: rtl/seq_divider.sv
// seq_divider: 32-bit restoring divider, start/done handshake, one quotient bit per cycle.
// Rev 1.0
`default_nettype none

module seq_divider
  import gravity_pkg::*;
#(
  parameter int Q_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        dividend,
  input  logic [31:0]        divisor,
  output logic               done,
  output logic [Q_WIDTH-1:0] quotient
);

  localparam int ITERS = DIV_CYCLES - 1;

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic [5:0]  cnt;
  logic        running;

  // The remainder after a successful subtract is below the divisor, so 32-bit wrap is exact.
  function automatic logic [63:0] div_step(input logic [31:0] r, input logic [31:0] q,
                                           input logic [31:0] d);
    logic [32:0] sh;
    sh = {r, q[31]};
    if (sh >= {1'b0, d}) div_step = {sh[31:0] - d, q[30:0], 1'b1};
    else                 div_step = {sh[31:0], q[30:0], 1'b0};
  endfunction

  // The first iteration happens on the start edge so the result lands DIV_CYCLES-1 edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        {rem, quo} <= div_step(32'd0, dividend, divisor);
        dvs        <= divisor;
        cnt        <= 6'd1;
        running    <= 1'b1;
      end else if (running) begin
        {rem, quo} <= div_step(rem, quo, dvs);
        cnt        <= cnt + 6'd1;
        if (cnt == 6'(ITERS - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo[Q_WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/gravity_row_reader.sv
// gravity_row_reader: reads binarized rows and accumulates per-frame pixel count, column and row sums.
// Define CENTROID_DIV_EN to add the oCX/oCY/oEMPTY centroid divide at frame end. Rev 1.0
`default_nettype none

module gravity_row_reader
  import gravity_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int MDATA_WIDTH = 640,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                   CCLK,
  input  logic                   RST_N,
  input  logic                   iROW_DONE,
  input  logic [ADDR_WIDTH-1:0]  iROW_ADDR,
  input  logic                   iROW_BANK,
  input  logic                   iFRAME_END,
  output logic                   oRD_EN,
  output logic [ADDR_WIDTH-1:0]  oRD_ADDR,
  output logic                   oRD_BANK,
  input  logic [MDATA_WIDTH-1:0] iRD_DATA,
  output logic [SUM_S_W-1:0]     oSUM_S,
  output logic [SUM_XY_W-1:0]    oSUM_X,
  output logic [SUM_XY_W-1:0]    oSUM_Y,
  output logic                   oVALID,
  output logic                   oBUSY,
  output logic                   oOVERRUN
`ifdef CENTROID_DIV_EN
  ,
  output logic [ADDR_WIDTH-1:0]  oCX,
  output logic [ADDR_WIDTH-1:0]  oCY,
  output logic                   oEMPTY
`endif
);

  localparam int NCHUNK = MDATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t                 state;
  logic [MDATA_WIDTH-1:0] row_sr;
  logic [CNT_W-1:0]       scan_cnt;
  logic [SUM_S_W-1:0]     acc_s;
  logic [SUM_XY_W-1:0]    acc_x;
  logic [SUM_XY_W-1:0]    acc_y;
  logic                   frame_pend;
  logic                   fin_now;

  logic [SUM_S_W-1:0]     pop;
  logic [SUM_XY_W-1:0]    x_inc;
  logic [SUM_XY_W-1:0]    y_inc;
  logic [SUM_XY_W-1:0]    base;

  // The low chunk of the shift register is always chunk scan_cnt of the captured row.
  always_comb begin
    base  = SUM_XY_W'(scan_cnt) * SUM_XY_W'(CHUNK_WIDTH);
    pop   = '0;
    x_inc = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (row_sr[i]) begin
        pop   = pop + SUM_S_W'(1);
        x_inc = x_inc + base + SUM_XY_W'(i);
      end
    end
    y_inc = SUM_XY_W'(pop) * SUM_XY_W'(oRD_ADDR);
  end

`ifdef CENTROID_DIV_EN
  logic                  div_started;
  logic                  div_start;
  logic                  done_x;
  logic                  done_y;
  logic [ADDR_WIDTH-1:0] q_x;
  logic [ADDR_WIDTH-1:0] q_y;

  assign div_start = (state == ST_FINAL) && !div_started;
  assign fin_now   = div_started && done_x && done_y;

  seq_divider #(.Q_WIDTH(ADDR_WIDTH)) u_div_x (
    .clk      (CCLK),
    .rst_n    (RST_N),
    .start    (div_start),
    .dividend (acc_x),
    .divisor  (SUM_XY_W'(acc_s)),
    .done     (done_x),
    .quotient (q_x)
  );

  seq_divider #(.Q_WIDTH(ADDR_WIDTH)) u_div_y (
    .clk      (CCLK),
    .rst_n    (RST_N),
    .start    (div_start),
    .dividend (acc_y),
    .divisor  (SUM_XY_W'(acc_s)),
    .done     (done_y),
    .quotient (q_y)
  );
`else
  assign fin_now = 1'b1;
`endif

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      row_sr     <= '0;
      scan_cnt   <= '0;
      acc_s      <= '0;
      acc_x      <= '0;
      acc_y      <= '0;
      frame_pend <= 1'b0;
      oRD_EN     <= 1'b0;
      oRD_ADDR   <= '0;
      oRD_BANK   <= 1'b0;
      oSUM_S     <= '0;
      oSUM_X     <= '0;
      oSUM_Y     <= '0;
      oVALID     <= 1'b0;
      oBUSY      <= 1'b0;
      oOVERRUN   <= 1'b0;
`ifdef CENTROID_DIV_EN
      div_started <= 1'b0;
      oCX         <= '0;
      oCY         <= '0;
      oEMPTY      <= 1'b0;
`endif
    end else begin
      oRD_EN <= 1'b0;
      oVALID <= 1'b0;
      if (iROW_DONE && state != ST_IDLE) oOVERRUN <= 1'b1;
      if (iFRAME_END && state != ST_IDLE) frame_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (iROW_DONE) begin
            oRD_ADDR <= iROW_ADDR;
            oRD_BANK <= iROW_BANK;
            oRD_EN   <= 1'b1;
            oBUSY    <= 1'b1;
            state    <= ST_READ;
            if (iFRAME_END) frame_pend <= 1'b1;
          end else if (iFRAME_END) begin
            oBUSY <= 1'b1;
            state <= ST_FINAL;
          end
        end
        ST_READ: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          row_sr   <= iRD_DATA;
          scan_cnt <= '0;
          state    <= ST_SCAN;
        end
        ST_SCAN: begin
          acc_s    <= acc_s + pop;
          acc_x    <= acc_x + x_inc;
          acc_y    <= acc_y + y_inc;
          row_sr   <= row_sr >> CHUNK_WIDTH;
          scan_cnt <= scan_cnt + CNT_W'(1);
          if (scan_cnt == CNT_W'(NCHUNK - 1)) begin
            // A frame end arriving on the last scan cycle has not reached frame_pend yet.
            if (frame_pend || iFRAME_END) begin
              state <= ST_FINAL;
            end else begin
              state <= ST_IDLE;
              oBUSY <= 1'b0;
            end
          end
        end
        ST_FINAL: begin
`ifdef CENTROID_DIV_EN
          if (div_start) div_started <= 1'b1;
`endif
          if (fin_now) begin
            oSUM_S     <= acc_s;
            oSUM_X     <= acc_x;
            oSUM_Y     <= acc_y;
            acc_s      <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            frame_pend <= 1'b0;
            oVALID     <= 1'b1;
            oBUSY      <= 1'b0;
            state      <= ST_IDLE;
`ifdef CENTROID_DIV_EN
            div_started <= 1'b0;
            oEMPTY      <= (acc_s == '0);
            oCX         <= (acc_s == '0) ? '0 : q_x;
            oCY         <= (acc_s == '0) ? '0 : q_y;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
